// File: rtl/ram8_loader_pkg.sv
// Shared types and sizes for the 8-word RAM preloader.
// Optional readback check is enabled with LOADER_VERIFY_EN.
package ram8_loader_pkg;

  localparam int unsigned RAM8_WORDS  = 8;
  localparam int unsigned RAM8_ADDR_W = 3;
  localparam int unsigned WORD_W      = 16;
  localparam int unsigned BYTE_W      = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RX_HI  = 3'd1,
    ST_RX_LO  = 3'd2,
    ST_WRITE  = 3'd3,
`ifdef LOADER_VERIFY_EN
    ST_VERIFY = 3'd4,
`endif
    ST_DONE   = 3'd5
  } state_t;

  typedef struct packed {
    logic [BYTE_W-1:0] hi;
    logic [BYTE_W-1:0] lo;
  } word_t;

  // Checksums wrap at 16 bits.
  function automatic logic [WORD_W-1:0] sum16(input logic [WORD_W-1:0] a,
                                              input logic [WORD_W-1:0] b);
    return WORD_W'(a + b);
  endfunction

endpackage

// File: rtl/ram8_loader_if.sv
// Byte-stream and RAM-port bundle between the loader and its environment.
interface ram8_loader_if;
  import ram8_loader_pkg::*;

  logic [BYTE_W-1:0]      byte_in;
  logic                   byte_valid;
  logic                   byte_ready;
  logic [WORD_W-1:0]      ram_in;
  logic                   ram_load;
  logic [RAM8_ADDR_W-1:0] ram_address;
  logic [WORD_W-1:0]      ram_out;

  modport master (
    output byte_in, byte_valid, ram_out,
    input  byte_ready, ram_in, ram_load, ram_address
  );

  modport slave (
    input  byte_in, byte_valid, ram_out,
    output byte_ready, ram_in, ram_load, ram_address
  );

endinterface

// File: rtl/ram8_loader_word_assembler.sv
// Two-byte shift-in register: high byte first, then low byte completes the word.
module word_assembler
  import ram8_loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load_hi,
  input  logic              load_lo,
  input  logic [BYTE_W-1:0] byte_in,
  output word_t             word,
  output logic              word_complete
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      word          <= '0;
      word_complete <= 1'b0;
    end else if (load_hi) begin
      word.hi       <= byte_in;
      word_complete <= 1'b0;
    end else if (load_lo) begin
      word.lo       <= byte_in;
      word_complete <= 1'b1;
    end
  end

endmodule

// File: rtl/ram8_loader.sv
// Fills the 8-word RAM from a byte stream after reset, one word per 3+ cycles.
// Define LOADER_VERIFY_EN to add a readback checksum pass and the error output.
module ram8_loader
  import ram8_loader_pkg::*;
#(
  parameter int unsigned WORDS = RAM8_WORDS
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           start,
  ram8_loader_if.slave   bus,
  output logic           busy,
  output logic           done
`ifdef LOADER_VERIFY_EN
  ,
  output logic           error
`endif
);

  localparam logic [RAM8_ADDR_W-1:0] LAST = RAM8_ADDR_W'(WORDS - 1);

  state_t                 state, state_d;
  logic [RAM8_ADDR_W-1:0] wc, wc_d;
  logic [WORD_W-1:0]      wsum, wsum_d;
  logic                   byte_ready_q, byte_ready_d;
  logic                   ram_load_q, ram_load_d;
  logic [RAM8_ADDR_W-1:0] ram_address_q, ram_address_d;
  logic                   busy_d, done_d;
  logic                   hs;
  logic                   restart;
  word_t                  word;
  logic                   word_ok;
`ifdef LOADER_VERIFY_EN
  logic [RAM8_ADDR_W-1:0] rc, rc_d;
  logic [WORD_W-1:0]      rsum, rsum_d;
  logic                   error_d;
`endif

  assign hs      = bus.byte_valid & byte_ready_q;
  assign restart = ((state == ST_IDLE) || (state == ST_DONE)) && start;

  word_assembler u_word_assembler (
    .clock         (clock),
    .reset_n       (reset_n),
    .load_hi       ((state == ST_RX_HI) && hs),
    .load_lo       ((state == ST_RX_LO) && hs),
    .byte_in       (bus.byte_in),
    .word          (word),
    .word_complete (word_ok)
  );

  assign bus.ram_in      = WORD_W'(word);
  assign bus.byte_ready  = byte_ready_q;
  assign bus.ram_load    = ram_load_q;
  assign bus.ram_address = ram_address_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_d = ST_RX_HI;
      ST_RX_HI:         if (hs)    state_d = ST_RX_LO;
      ST_RX_LO:         if (hs)    state_d = ST_WRITE;
      ST_WRITE: begin
        if (wc == LAST) begin
`ifdef LOADER_VERIFY_EN
          state_d = ST_VERIFY;
`else
          state_d = ST_DONE;
`endif
        end else begin
          state_d = ST_RX_HI;
        end
      end
`ifdef LOADER_VERIFY_EN
      ST_VERIFY:        if (rc == LAST) state_d = ST_DONE;
`endif
      default:          state_d = ST_IDLE;
    endcase
  end

  // Next values of counters, sums and the registered outputs.
  always_comb begin
    wc_d          = wc;
    wsum_d        = wsum;
    ram_address_d = ram_address_q;
`ifdef LOADER_VERIFY_EN
    rc_d          = rc;
    rsum_d        = rsum;
    error_d       = error;
`endif

    if (restart) begin
      wc_d   = '0;
      wsum_d = '0;
`ifdef LOADER_VERIFY_EN
      rc_d    = '0;
      rsum_d  = '0;
      error_d = 1'b0;
`endif
    end

    if (state == ST_WRITE) begin
      if (word_ok) wsum_d = sum16(wsum, WORD_W'(word));
      if (wc != LAST) wc_d = wc + 1'b1;
    end

`ifdef LOADER_VERIFY_EN
    // RAM read is combinational, so ram_out belongs to this cycle's address.
    if (state == ST_VERIFY) begin
      rsum_d = sum16(rsum, bus.ram_out);
      if (rc == LAST) error_d = (rsum_d != wsum);
      else            rc_d    = rc + 1'b1;
    end
    if (state_d == ST_VERIFY) ram_address_d = rc_d;
`endif

    if (state_d == ST_WRITE) ram_address_d = wc_d;

    byte_ready_d = (state_d == ST_RX_HI) || (state_d == ST_RX_LO);
    ram_load_d   = (state_d == ST_WRITE);
    done_d       = (state_d == ST_DONE);
`ifdef LOADER_VERIFY_EN
    busy_d       = byte_ready_d || ram_load_d || (state_d == ST_VERIFY);
`else
    busy_d       = byte_ready_d || ram_load_d;
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wc            <= '0;
      wsum          <= '0;
      byte_ready_q  <= 1'b0;
      ram_load_q    <= 1'b0;
      ram_address_q <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
`ifdef LOADER_VERIFY_EN
      rc            <= '0;
      rsum          <= '0;
      error         <= 1'b0;
`endif
    end else begin
      wc            <= wc_d;
      wsum          <= wsum_d;
      byte_ready_q  <= byte_ready_d;
      ram_load_q    <= ram_load_d;
      ram_address_q <= ram_address_d;
      busy          <= busy_d;
      done          <= done_d;
`ifdef LOADER_VERIFY_EN
      rc            <= rc_d;
      rsum          <= rsum_d;
      error         <= error_d;
`endif
    end
  end

endmodule

// File: tb/tb_ram8_loader.sv
// Bench for ram8_loader: two loaders (WORDS=8 and WORDS=3) each driving a RAM model.
// Honors LOADER_VERIFY_EN for the readback-check scenarios.
module tb_ram8_loader;
  import ram8_loader_pkg::*;

`ifdef LOADER_VERIFY_EN
  localparam int DONE_CYC = 33;
`else
  localparam int DONE_CYC = 25;
`endif

  logic clock = 1'b0;
  logic reset_n, start_a, start_b;
  logic busy_a, done_a, busy_b, done_b;
`ifdef LOADER_VERIFY_EN
  logic error_a, error_b;
`endif
  logic [7:0]  src_byte;
  logic        src_valid;
  logic        poke_a, poke_b;
  logic [2:0]  poke_addr;
  logic [15:0] poke_data;

  int vectors = 0;
  int errors  = 0;
  int load_cnt;
  int cyc;
  logic [18:0] sb[$];

  logic [15:0] mem_a [8];
  logic [15:0] mem_b [8];
  logic [15:0] cur   [8];
  logic [15:0] p1 [8] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0,
                          16'h2345, 16'h6789, 16'hABCD, 16'hEF01};
  logic [15:0] p2 [8] = '{16'h0F1E, 16'h2D3C, 16'h4B5A, 16'h6978,
                          16'h8796, 16'hA5B4, 16'hC3D2, 16'hE1F0};
  logic [15:0] p3 [8] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                          16'h5555, 16'h6666, 16'h7777, 16'h8888};

  always #5 clock = ~clock;

  ram8_loader_if if_a ();
  ram8_loader_if if_b ();

  assign if_a.byte_in    = src_byte;
  assign if_a.byte_valid = src_valid;
  assign if_b.byte_in    = src_byte;
  assign if_b.byte_valid = src_valid;

  always @(posedge clock) begin
    if (if_a.ram_load) mem_a[if_a.ram_address] <= if_a.ram_in;
    else if (poke_a)   mem_a[poke_addr]        <= poke_data;
    if (if_b.ram_load) mem_b[if_b.ram_address] <= if_b.ram_in;
    else if (poke_b)   mem_b[poke_addr]        <= poke_data;
  end
  assign if_a.ram_out = mem_a[if_a.ram_address];
  assign if_b.ram_out = mem_b[if_b.ram_address];

  ram8_loader #(.WORDS(8)) dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start_a),
    .bus     (if_a.slave),
    .busy    (busy_a),
    .done    (done_a)
`ifdef LOADER_VERIFY_EN
    ,
    .error   (error_a)
`endif
  );

  ram8_loader #(.WORDS(3)) dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start_b),
    .bus     (if_b.slave),
    .busy    (busy_b),
    .done    (done_b)
`ifdef LOADER_VERIFY_EN
    ,
    .error   (error_b)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Every write pulse on instance A is matched against the scoreboard.
  always @(negedge clock) begin
    if (if_a.ram_load === 1'b1) begin
      load_cnt++;
      if (sb.size() == 0) begin
        vectors++;
        errors++;
        $error("FAIL sb_underflow observed=%h expected=none", {if_a.ram_address, if_a.ram_in});
      end else begin
        chk("ram_write", 32'({if_a.ram_address, if_a.ram_in}), 32'(sb.pop_front()));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin
      src_valid = 1'b0;
      @(negedge clock);
    end
    src_valid = 1'b1;
    src_byte  = b;
    t = 0;
    while (((if_a.byte_ready | if_b.byte_ready) !== 1'b1) && t < 100) begin
      @(negedge clock);
      t++;
    end
    if (t >= 100) begin
      vectors++;
      errors++;
      $error("FAIL byte_timeout observed=no_ready expected=ready byte=%h", b);
    end
    @(negedge clock);
    src_valid = 1'b0;
  endtask

  task automatic feed(input int n, input int maxgap);
    for (int i = 0; i < n; i++) begin
      send_byte(cur[i][15:8], int'($urandom_range(0, maxgap)));
      send_byte(cur[i][7:0],  int'($urandom_range(0, maxgap)));
    end
  endtask

  task automatic push_sb(input int n);
    for (int i = 0; i < n; i++) sb.push_back({3'(i), cur[i]});
  endtask

  task automatic wait_done(input bit sel);
    int t;
    t = 0;
    while (((sel ? done_b : done_a) !== 1'b1) && t < 400) begin
      @(negedge clock);
      t++;
    end
  endtask

  task automatic poke(input bit sel, input int addr, input logic [15:0] d);
    poke_a    = !sel;
    poke_b    = sel;
    poke_addr = 3'(addr);
    poke_data = d;
    @(negedge clock);
    poke_a = 1'b0;
    poke_b = 1'b0;
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
  endtask

  task automatic check_mem_a(input string tag);
    for (int i = 0; i < 8; i++) chk(tag, 32'(mem_a[i]), 32'(cur[i]));
  endtask

  initial begin
    reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    src_valid = 1'b0; src_byte = '0;
    poke_a = 1'b0; poke_b = 1'b0; poke_addr = '0; poke_data = '0;
    load_cnt = 0;
    repeat (2) @(negedge clock);

    chk("rst_busy",    32'(busy_a), 32'(0));
    chk("rst_done",    32'(done_a), 32'(0));
    chk("rst_load",    32'(if_a.ram_load), 32'(0));
    chk("rst_ready",   32'(if_a.byte_ready), 32'(0));
    chk("rst_address", 32'(if_a.ram_address), 32'(0));
    chk("rst_ram_in",  32'(if_a.ram_in), 32'(0));
`ifdef LOADER_VERIFY_EN
    chk("rst_error",   32'(error_a), 32'(0));
`endif
    reset_n = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      poke(1'b0, i, 16'hA500 + 16'(i));
      poke(1'b1, i, 16'hB500 + 16'(i));
    end

    // Continuous stream: done at cycle DONE_CYC counting the first ready as 1.
    cur = p1;
    push_sb(8);
    load_cnt = 0;
    pulse_start_a();
    cyc = 1;
    fork
      feed(8, 0);
      begin
        while (done_a !== 1'b1 && cyc < 200) begin
          @(negedge clock);
          cyc++;
        end
      end
    join
    chk("t1_done_cycle", 32'(cyc), 32'(DONE_CYC));
    chk("t1_done", 32'(done_a), 32'(1));
    chk("t1_busy", 32'(busy_a), 32'(0));
    chk("t1_loads", 32'(load_cnt), 32'(8));
    check_mem_a("t1_mem");
`ifdef LOADER_VERIFY_EN
    chk("t1_error", 32'(error_a), 32'(0));
`endif

    // Random valid gaps, RAM cleared first so contents come only from this load.
    for (int i = 0; i < 8; i++) poke(1'b0, i, 16'h0000);
    push_sb(8);
    load_cnt = 0;
    pulse_start_a();
    feed(8, 5);
    wait_done(1'b0);
    chk("t2_done", 32'(done_a), 32'(1));
    chk("t2_loads", 32'(load_cnt), 32'(8));
    chk("t2_sb_left", 32'(sb.size()), 32'(0));
    check_mem_a("t2_mem");

    // Start pulses while busy must not restart the load.
    cur = p2;
    push_sb(8);
    load_cnt = 0;
    pulse_start_a();
    fork
      feed(8, 2);
      begin
        repeat (10) @(negedge clock);
        pulse_start_a();
        repeat (7) @(negedge clock);
        pulse_start_a();
      end
    join
    wait_done(1'b0);
    chk("t3_done", 32'(done_a), 32'(1));
    chk("t3_loads", 32'(load_cnt), 32'(8));
    chk("t3_sb_left", 32'(sb.size()), 32'(0));
    check_mem_a("t3_mem");

    // Start from DONE clears done and begins a fresh load.
    cur = p1;
    push_sb(8);
    pulse_start_a();
    chk("t4_done_clr", 32'(done_a), 32'(0));
    chk("t4_busy", 32'(busy_a), 32'(1));
    chk("t4_ready", 32'(if_a.byte_ready), 32'(1));
    feed(8, 1);
    wait_done(1'b0);
    chk("t4_done", 32'(done_a), 32'(1));
    check_mem_a("t4_mem");

    // Reset during the 4th WRITE: no write of word 3, back to IDLE.
    cur = p3;
    push_sb(4);
    pulse_start_a();
    feed(4, 0);
    chk("t5_in_write", 32'(if_a.ram_load), 32'(1));
    chk("t5_write_addr", 32'(if_a.ram_address), 32'(3));
    #2 reset_n = 1'b0;
    #1;
    chk("t5_load_drop", 32'(if_a.ram_load), 32'(0));
    chk("t5_busy", 32'(busy_a), 32'(0));
    chk("t5_ready", 32'(if_a.byte_ready), 32'(0));
    chk("t5_address", 32'(if_a.ram_address), 32'(0));
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("t5_mem3_kept", 32'(mem_a[3]), 32'(p1[3]));
    chk("t5_mem2_new", 32'(mem_a[2]), 32'(p3[2]));
    chk("t5_done", 32'(done_a), 32'(0));
    chk("t5_sb_left", 32'(sb.size()), 32'(0));

    // WORDS=3 instance writes addresses 0..2 only.
    cur = p2;
    start_b = 1'b1;
    @(negedge clock);
    start_b = 1'b0;
    feed(3, 1);
    wait_done(1'b1);
    chk("t6_done", 32'(done_b), 32'(1));
    chk("t6_busy", 32'(busy_b), 32'(0));
    for (int i = 0; i < 3; i++) chk("t6_mem_written", 32'(mem_b[i]), 32'(p2[i]));
    for (int i = 3; i < 8; i++) chk("t6_mem_untouched", 32'(mem_b[i]), 32'(16'hB500 + 16'(i)));
`ifdef LOADER_VERIFY_EN
    chk("t6_error", 32'(error_b), 32'(0));

    // Corrupt RAM[5] after the last WRITE, before it is read back.
    cur = p1;
    push_sb(8);
    pulse_start_a();
    fork
      feed(8, 0);
      begin
        int t;
        t = 0;
        while (!(if_a.ram_load === 1'b1 && if_a.ram_address === 3'd7) && t < 300) begin
          @(negedge clock);
          t++;
        end
        @(negedge clock);
        poke(1'b0, 5, ~p1[5]);
      end
    join
    wait_done(1'b0);
    chk("t7_done", 32'(done_a), 32'(1));
    chk("t7_error", 32'(error_a), 32'(1));

    push_sb(8);
    pulse_start_a();
    chk("t7_error_clr", 32'(error_a), 32'(0));
    feed(8, 0);
    wait_done(1'b0);
    chk("t7_clean_done", 32'(done_a), 32'(1));
    chk("t7_clean_error", 32'(error_a), 32'(0));
`endif

    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
